// File: rtl/counter_updown_param.sv
`default_nettype none
// ============================================================================
// Module   : counter_updown_param
// Brief    : Parametrised up/down modulus counter with clear, clamped load,
//            wrap/saturate bounds and registered overflow/underflow pulses.
// Revision : 1.0 - initial release
// ============================================================================
module counter_updown_param #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             EN,
  input  logic             CLR,
  input  logic             LD,
  input  logic             UP,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             OV,
  output logic             UF,
  output logic             TC
);

  localparam logic [WIDTH-1:0] c_max_val = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_zero    = '0;

  logic [WIDTH-1:0] counter_q;
  logic [WIDTH-1:0] counter_d;
  logic             ov_q;
  logic             ov_d;
  logic             uf_q;
  logic             uf_d;

  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_top_next;
  logic [WIDTH-1:0] w_bot_next;
  logic [WIDTH-1:0] w_load_clamped;

  assign w_at_max       = (counter_q == c_max_val);
  assign w_at_zero      = (counter_q == c_zero);
  assign w_load_clamped = (load_val > c_max_val) ? c_max_val : load_val;

  // Value taken when stepping past a bound: hold it, or wrap to the opposite end.
  if (SATURATE) begin : g_saturate
    assign w_top_next = c_max_val;
    assign w_bot_next = c_zero;
  end else begin : g_wrap
    assign w_top_next = c_zero;
    assign w_bot_next = c_max_val;
  end

  always_comb begin
    counter_d = counter_q;
    ov_d      = 1'b0;
    uf_d      = 1'b0;
    if (CLR) begin
      counter_d = c_zero;
    end else if (LD) begin
      counter_d = w_load_clamped;
    end else if (EN) begin
      if (UP) begin
        if (w_at_max) begin
          counter_d = w_top_next;
          ov_d      = 1'b1;
        end else begin
          counter_d = counter_q + c_one;
        end
      end else begin
        if (w_at_zero) begin
          counter_d = w_bot_next;
          uf_d      = 1'b1;
        end else begin
          counter_d = counter_q - c_one;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      counter_q <= c_zero;
      ov_q      <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      counter_q <= counter_d;
      ov_q      <= ov_d;
      uf_q      <= uf_d;
    end
  end

  assign counter = counter_q;
  assign OV      = ov_q;
  assign UF      = uf_q;
  // Terminal count reflects the live direction input, not a registered copy.
  assign TC      = UP ? w_at_max : w_at_zero;

endmodule
`default_nettype wire
